// File: rtl/cpu_pkg.sv
// Shared definitions for the single-issue MIPS core front end.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'b00,
        REDIR_BR   = 2'b01,
        REDIR_J    = 2'b10,
        REDIR_JR   = 2'b11
    } redir_kind_e;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } if_state_e;

endpackage

// File: rtl/npc_calc.sv
// Redirect target computation for branch, jump and jump-register.
module npc_calc
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic [PC_W-1:0] pc_out,
    input  logic [1:0]      redir_kind,
    input  logic [15:0]     br_offset,
    input  logic [25:0]     j_target,
    input  logic [PC_W-1:0] jr_addr,
    output logic [PC_W-1:0] target
);

    logic [PC_W-1:0] base;
    logic [PC_W-1:0] br_disp;

    assign base    = pc_out + PC_W'(4);
    assign br_disp = {{(PC_W-18){br_offset[15]}}, br_offset, 2'b00};

    always_comb begin
        target = base;
        case (redir_kind_e'(redir_kind))
            REDIR_BR: target = base + br_disp;
            REDIR_J:  target = {base[PC_W-1:PC_W-4], j_target, 2'b00};
            REDIR_JR: target = {jr_addr[PC_W-1:2], 2'b00};
            default:  target = base;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over req/ready, buffers one
// instruction for decode and handles redirects from decode.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0]  RESET_PC = RESET_PC_DEF,
    parameter int unsigned  PC_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_out,
    output logic [PC_W-1:0]    pc_out,
    input  logic [1:0]         redir_kind,
    input  logic [15:0]        br_offset,
    input  logic [25:0]        j_target,
    input  logic [PC_W-1:0]    jr_addr
);

    if_state_e          state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc_out_d;
    logic [INSTR_W-1:0] ir_out_d;
    logic               ir_valid_d;
    logic [PC_W-1:0]    target;
    logic               space;
    logic               redir;
    logic               fire;

    npc_calc #(.PC_W(PC_W)) u_npc (
        .pc_out     (pc_out),
        .redir_kind (redir_kind),
        .br_offset  (br_offset),
        .j_target   (j_target),
        .jr_addr    (jr_addr),
        .target     (target)
    );

    // Request is suppressed while reset is asserted so a late response is ignored.
    assign space     = !ir_valid || ir_ready;
    assign imem_req  = rst_n && ((state_q == FETCH && space) || state_q == DISCARD);
    assign imem_addr = pc_q;
    assign redir     = redir_kind != REDIR_NONE;
    assign fire      = imem_req && imem_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_out_d   = pc_out;
        ir_out_d   = ir_out;
        ir_valid_d = ir_valid;
        if (redir) begin
            // Flush the buffer; an unanswered request leaves a stale response to drop.
            pc_d       = target;
            ir_valid_d = 1'b0;
            if (fire) begin
                state_d = FETCH;
            end else if (imem_req) begin
                state_d = DISCARD;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (fire) begin
                        ir_out_d   = imem_rdata;
                        pc_out_d   = pc_q;
                        ir_valid_d = 1'b1;
                        pc_d       = pc_q + PC_W'(4);
                    end else if (ir_valid && ir_ready) begin
                        ir_valid_d = 1'b0;
                    end
                end
                DISCARD: begin
                    if (imem_ready) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= PC_W'(RESET_PC);
            ir_valid <= 1'b0;
            ir_out   <= '0;
            pc_out   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_valid <= ir_valid_d;
            ir_out   <= ir_out_d;
            pc_out   <= pc_out_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vectors with literal checks plus a per-cycle
// comparison against a transaction-level model of the fetch stage.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_out;
    logic [31:0] pc_out;
    logic [1:0]  redir_kind;
    logic [15:0] br_offset;
    logic [25:0] j_target;
    logic [31:0] jr_addr;

    int n_chk  = 0;
    int n_fail = 0;

    if_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_out     (ir_out),
        .pc_out     (pc_out),
        .redir_kind (redir_kind),
        .br_offset  (br_offset),
        .j_target   (j_target),
        .jr_addr    (jr_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a == 32'h0000_3000) ? 32'h8C01_0004 : (a ^ 32'h2400_0000);
    endfunction

    assign imem_rdata = word_of(imem_addr);

    // Model: next fetch address, whether a stale response is still owed,
    // and the instruction buffer contents.
    logic        m_init = 1'b0;
    logic [31:0] m_pc;
    logic        m_stale;
    logic        m_valid;
    logic [31:0] m_ir;
    logic [31:0] m_pco;

    function automatic logic m_req_now();
        if (!rst_n) return 1'b0;
        return m_stale || !m_valid || ir_ready;
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] base;
        base = m_pco + 32'd4;
        case (redir_kind)
            2'd1:    return base + 32'($signed(br_offset)) * 32'd4;
            2'd2:    return (base & 32'hF000_0000) | (32'(j_target) * 32'd4);
            default: return jr_addr & 32'hFFFF_FFFC;
        endcase
    endfunction

    always @(posedge clk) begin
        logic req;
        req = m_req_now();
        if (!rst_n) begin
            m_init  = 1'b1;
            m_pc    = 32'h0000_3000;
            m_stale = 1'b0;
            m_valid = 1'b0;
            m_ir    = 32'h0;
            m_pco   = 32'h0;
        end else if (m_init) begin
            if (redir_kind != 2'd0) begin
                m_pc    = m_target();
                m_valid = 1'b0;
                if (req && imem_ready) m_stale = 1'b0;
                else if (req)          m_stale = 1'b1;
            end else if (m_stale) begin
                if (imem_ready) m_stale = 1'b0;
            end else if (req && imem_ready) begin
                m_ir    = word_of(m_pc);
                m_pco   = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end else if (m_valid && ir_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            chk("model_req", 32'(imem_req), 32'(m_req_now()));
            chk("model_addr", imem_addr, m_pc);
            chk("model_valid", 32'(ir_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model_ir", ir_out, m_ir);
                chk("model_pc_out", pc_out, m_pco);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        ir_ready   = 1'b1;
        redir_kind = 2'd0;
        br_offset  = 16'h0;
        j_target   = 26'h0;
        jr_addr    = 32'h0;
        step();
        step();
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_ir_out", ir_out, 32'h0);
        chk("rst_addr", imem_addr, 32'h0000_3000);
        chk("rst_req", 32'(imem_req), 32'd0);

        rst_n = 1'b1; imem_ready = 1'b1;
        #1;
        chk("post_rst_req", 32'(imem_req), 32'd1);
        step();
        chk("first_valid", 32'(ir_valid), 32'd1);
        chk("first_ir", ir_out, 32'h8C01_0004);
        chk("first_pc_out", pc_out, 32'h0000_3000);
        chk("first_addr", imem_addr, 32'h0000_3004);

        ir_ready = 1'b0;
        #1;
        chk("stall_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ir", ir_out, 32'h8C01_0004);
            chk("stall_pc_out", pc_out, 32'h0000_3000);
            chk("stall_addr", imem_addr, 32'h0000_3004);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        ir_ready = 1'b1;
        step();
        chk("b2b_pc_out", pc_out, 32'h0000_3004);
        chk("b2b_ir", ir_out, 32'h2400_3004);
        step();
        chk("b2b_pc_out2", pc_out, 32'h0000_3008);
        chk("b2b_addr2", imem_addr, 32'h0000_300C);

        redir_kind = 2'd1; br_offset = 16'hFFFE;
        step();
        chk("br_valid", 32'(ir_valid), 32'd0);
        chk("br_addr", imem_addr, 32'h0000_3004);
        redir_kind = 2'd0;
        step();
        chk("br_fetch_pc_out", pc_out, 32'h0000_3004);
        step(); step(); step();
        chk("pre_j_pc_out", pc_out, 32'h0000_3010);

        redir_kind = 2'd2; j_target = 26'h0000C10;
        step();
        chk("j_addr", imem_addr, 32'h0000_3040);
        chk("j_valid", 32'(ir_valid), 32'd0);
        redir_kind = 2'd0;
        step();
        chk("j_pc_out", pc_out, 32'h0000_3040);

        redir_kind = 2'd3; jr_addr = 32'h0000_3057;
        step();
        chk("jr_addr", imem_addr, 32'h0000_3054);
        redir_kind = 2'd0;
        step();
        chk("jr_pc_out", pc_out, 32'h0000_3054);

        imem_ready = 1'b0;
        step();
        chk("wait_valid", 32'(ir_valid), 32'd0);
        redir_kind = 2'd3; jr_addr = 32'h0000_4000;
        step();
        chk("disc_addr", imem_addr, 32'h0000_4000);
        chk("disc_req", 32'(imem_req), 32'd1);
        redir_kind = 2'd0;
        step();
        chk("disc_valid", 32'(ir_valid), 32'd0);
        imem_ready = 1'b1;
        step();
        chk("disc_drop_valid", 32'(ir_valid), 32'd0);
        chk("disc_drop_addr", imem_addr, 32'h0000_4000);
        step();
        chk("disc_next_pc_out", pc_out, 32'h0000_4000);
        chk("disc_next_ir", ir_out, 32'h2400_4000);
        chk("disc_next_addr", imem_addr, 32'h0000_4004);

        imem_ready = 1'b0;
        step();
        redir_kind = 2'd3; jr_addr = 32'h0000_5000;
        step();
        chk("disc2_addr", imem_addr, 32'h0000_5000);
        redir_kind = 2'd0; rst_n = 1'b0; imem_ready = 1'b1;
        #1;
        chk("rst_disc_req", 32'(imem_req), 32'd0);
        step();
        chk("rst_disc_valid", 32'(ir_valid), 32'd0);
        chk("rst_disc_addr", imem_addr, 32'h0000_3000);
        rst_n = 1'b1;
        step();
        chk("rst_disc_ir", ir_out, 32'h8C01_0004);
        chk("rst_disc_pc_out", pc_out, 32'h0000_3000);

        redir_kind = 2'd3; jr_addr = 32'hFFFF_FFFC;
        step();
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        redir_kind = 2'd0;
        step();
        chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wrap_ir", ir_out, 32'hDBFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        for (int i = 0; i < 400; i++) begin
            imem_ready = ($urandom_range(0, 2) != 0);
            ir_ready   = ($urandom_range(0, 3) != 0);
            redir_kind = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            br_offset  = 16'($urandom);
            j_target   = 26'($urandom);
            jr_addr    = $urandom;
            step();
        end
        redir_kind = 2'd0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the single-issue MIPS core. It sits directly upstream of the instruction field splitter.
- Owns the PC and issues word fetches to instruction memory over a req/ready handshake.
- Buffers one fetched instruction and presents it with its PC to decode over a valid/ready handshake.
- Accepts branch, jump and jump-register redirects from decode, flushing its buffer and any in-flight fetch on each redirect.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset; low 2 bits must be 0.
- PC_W, 32, PC and address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request; held high with a stable imem_addr until imem_ready.
- imem_addr  out  32  word-aligned fetch address (= pc).
- imem_ready  in  1  response valid; imem_rdata sampled this cycle.
- imem_rdata  in  32  fetched instruction word.
- ir_valid  out  1  ir_out/pc_out hold a valid instruction for decode.
- ir_ready  in  1  decode consumes ir_out this cycle when ir_valid is high.
- ir_out  out  32  instruction word to the field splitter.
- pc_out  out  32  address of ir_out.
- redir_kind  in  2  00 none, 01 branch, 10 jump, 11 jump-register.
- br_offset  in  16  branch immediate (im[15:0]).
- j_target  in  26  jump index (im[25:0]).
- jr_addr  in  32  register-sourced target.

Behaviour:
- Reset (rst_n=0 at clk edge): pc=RESET_PC, state=FETCH, ir_valid=0, ir_out=0, pc_out=0. imem_req is 0 during the reset cycle and 1 from the first cycle after reset.
- Buffer space rule: space = !ir_valid || ir_ready.
- imem_req = (state==FETCH && space) || state==DISCARD.
- imem_addr = pc at all times. pc changes only on accepted fetch, on redirect, or on reset.

States:
- FETCH
  - If imem_req && imem_ready and no redirect:
    - ir_out <= imem_rdata, pc_out <= pc, ir_valid <= 1, pc <= pc+4.
    - Latency: response cycle -> ir_valid high the next cycle.
  - Else if the buffer is consumed (ir_valid && ir_ready) with no new fetch: ir_valid <= 0.
- DISCARD (a fetch was in flight when redirect arrived)
  - imem_req stays 1 with imem_addr = the new pc; the memory owns the old address.
  - On imem_ready: drop imem_rdata, state <= FETCH. The next request then uses the new pc.

Redirect (redir_kind != 0), sampled any cycle, highest priority after reset:
- Target base = pc_out+4.
- 01 branch: base + (sign_extend(br_offset) << 2), mod 2^32.
- 10 jump: {base[31:28], j_target, 2'b00}.
- 11 jump-register: {jr_addr[31:2], 2'b00}. Misalignment is silently cleared.
- Actions: pc <= target, ir_valid <= 0 (buffer flushed regardless of ir_ready).
- If imem_req was high and imem_ready low that cycle: state <= DISCARD.
- If imem_ready was high that same cycle: the response is dropped, state <= FETCH.
- Redirect while already in DISCARD: pc updated, stay in DISCARD.

Boundaries:
- Buffer full, no ir_ready: imem_req=0, pc held, ir_out/pc_out stable.
- Full and ir_ready and imem_ready in the same cycle: replace the buffer back-to-back. Throughput is 1 instr/cycle.
- pc+4 at 32'hFFFF_FFFC wraps to 0.
- Reset mid-fetch or in DISCARD: immediate return to reset values. Any late imem_ready is ignored because imem_req=0 that cycle.

Decomposition:
- Shared package cpu_pkg:
  - RESET_PC default.
  - redirect kind constants REDIR_NONE/BR/J/JR.
  - state encoding FETCH/DISCARD.
  - INSTR_W=32.
- Sub-module npc_calc (combinational): inputs pc_out, redir_kind, br_offset, j_target, jr_addr; output target.
- PC register, state machine and buffer stay in if_stage.

Test Plan:
- Reset, imem_ready tied 1, ir_ready tied 1 -> imem_addr 3000,3004,3008 on consecutive cycles; ir_valid from the cycle after the first response; pc_out tracks with one-cycle lag.
- ir_ready=0 for 3 cycles after the first instruction 32'h8C010004 -> ir_out/pc_out stable at 8C010004/3000, imem_req=0, imem_addr=3004 held.
- Branch with pc_out=3008, br_offset=16'hFFFE -> pc=3004, ir_valid=0 next cycle; next fetch address 3004.
- Jump with pc_out=3010, j_target=26'h0000C10 -> next address 32'h0000_3040. jr_addr=32'h0000_3057 -> next address 3054.
- imem_ready held low 2 cycles after a request, redirect to 4000 in the first wait cycle -> state DISCARD; the returning word is not presented (ir_valid stays 0); next request address 4000.
- rst_n=0 in DISCARD with imem_ready=1 -> next cycle ir_valid=0, pc=3000, state FETCH; the discarded word never appears.
